seg7_scan_driver: RTL and testbench

- Parametrised, time-multiplexed N-digit seven-segment driver. Sits between the state-to-display mux and the board's anode/cathode pins.
- Takes a packed nibble-per-digit word and scans one digit per refresh slot.
- Adds tear-free frame-synchronous loading, per-digit blank/blink/decimal-point masks, and a frame-start strobe.

---
 rtl/seg7_scan_driver.sv | 213 +++++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed N-digit seven-segment driver. Scans one digit per refresh
// slot, loads new display content only on frame boundaries (no tearing), and
// applies per-digit blank / blink / decimal-point masks. All pin outputs are
// registered; an/seg/dp are active-low, seg is ordered {g,f,e,d,c,b,a}.
//
// Optional build macro:
//   SEG7_LEADING_ZERO_BLANK_EN - when defined, a zero digit k > 0 goes dark
//   if every more-significant digit is 0 or F. Digit 0 always shows, and the
//   decimal point is still driven from dp_mask on a suppressed digit.

module seg7_scan_driver #(
   parameter int NUM_DIGITS   = 8,       // 1..16
   parameter int REFRESH_DIV  = 100000,  // clk cycles per digit slot, >= 2
   parameter int BLINK_FRAMES = 250      // frames per blink half-period, >= 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] display_data,
   input  logic                    load,
   input  logic [NUM_DIGITS-1:0]   blank_mask,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   input  logic [NUM_DIGITS-1:0]   dp_mask,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic                    frame_start
);

   localparam int CW = (REFRESH_DIV  > 1) ? $clog2(REFRESH_DIV)  : 1;
   localparam int IW = (NUM_DIGITS   > 1) ? $clog2(NUM_DIGITS)   : 1;
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

   localparam logic [6:0] SEG_DARK = 7'h7F;

   // One complete display image: nibbles plus the three per-digit masks.
   typedef struct packed {
      logic [4*NUM_DIGITS-1:0] data;
      logic [NUM_DIGITS-1:0]   blank;
      logic [NUM_DIGITS-1:0]   blink;
      logic [NUM_DIGITS-1:0]   dp;
   } frame_t;

   localparam frame_t FRAME_RESET = '{data: '1, blank: '0, blink: '0, dp: '0};

   // Scan timing state
   logic [CW-1:0] refresh_cnt;
   logic [IW-1:0] digit_idx;
   logic          tick;
   logic          boundary;
   logic          boundary_d;

   // Blink state
   logic [BW-1:0] blink_cnt;
   logic          blink_on;

   // Double-buffered display image
   frame_t        load_img;
   frame_t        pending;
   frame_t        shadow;
   logic          pending_valid;

   // Current-digit selections feeding the output registers
   logic [3:0]            cur_nib;
   logic                  cur_blank;
   logic                  cur_blink;
   logic                  cur_dp;
   logic                  cur_lz;
   logic                  hard_dark;
   logic [NUM_DIGITS-1:0] lz_dark;
   logic [NUM_DIGITS-1:0] an_next;

   // Nibble to active-low {g,f,e,d,c,b,a}; F is the blank code.
   function automatic logic [6:0] decode(input logic [3:0] nib);
      case (nib)
         4'h0:    return 7'h40;
         4'h1:    return 7'h79;
         4'h2:    return 7'h24;
         4'h3:    return 7'h30;
         4'h4:    return 7'h19;
         4'h5:    return 7'h12;
         4'h6:    return 7'h02;
         4'h7:    return 7'h78;
         4'h8:    return 7'h00;
         4'h9:    return 7'h10;
         4'hA:    return 7'h08;
         4'hB:    return 7'h03;
         4'hC:    return 7'h46;
         4'hD:    return 7'h21;
         4'hE:    return 7'h06;
         default: return SEG_DARK;
      endcase
   endfunction

   assign tick     = (refresh_cnt == CNT_LAST);
   assign boundary = tick && (digit_idx == IDX_LAST);
   assign load_img = '{data: display_data, blank: blank_mask,
                       blink: blink_mask, dp: dp_mask};

   // Refresh divider and digit index: one slot per REFRESH_DIV clocks.
   // NOTE: sequential state uses <= so every flop samples pre-edge values;
   // a blocking = here would let later statements see already-updated state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         refresh_cnt <= '0;
         digit_idx   <= '0;
      end else if (tick) begin
         refresh_cnt <= '0;
         if (digit_idx == IDX_LAST) digit_idx <= '0;
         else                       digit_idx <= digit_idx + IW'(1);
      end else begin
         refresh_cnt <= refresh_cnt + CW'(1);
      end
   end

   // Blink phase: toggles after BLINK_FRAMES frame boundaries.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_cnt <= '0;
         blink_on  <= 1'b1;
      end else if (boundary) begin
         if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
         end else begin
            blink_cnt <= blink_cnt + BW'(1);
         end
      end
   end

   // Pending/shadow buffering: shadow only changes on a frame boundary, and a
   // load that coincides with the boundary bypasses pending entirely.
   // NOTE: pending and shadow are plain flops rather than a memory, so they
   // take the reset like any other state; that is what makes the display
   // come up blank instead of showing garbage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending       <= FRAME_RESET;
         shadow        <= FRAME_RESET;
         pending_valid <= 1'b0;
      end else if (boundary) begin
         if (load)               shadow <= load_img;
         else if (pending_valid) shadow <= pending;
         pending_valid <= 1'b0;
      end else if (load) begin
         pending       <= load_img;
         pending_valid <= 1'b1;
      end
   end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   // Leading-zero suppression, scanning from the most-significant digit down.
   always_comb begin
      logic       upper_empty;
      logic [3:0] nib;
      lz_dark     = '0;
      upper_empty = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         nib = shadow.data[4*k +: 4];
         if ((k > 0) && upper_empty && (nib == 4'h0)) lz_dark[k] = 1'b1;
         upper_empty = upper_empty && ((nib == 4'h0) || (nib == 4'hF));
      end
   end
`else
   assign lz_dark = '0;
`endif

   // Select the active digit's nibble and masks, and build the anode pattern.
   // NOTE: every variable written here gets a default before the loop, so no
   // path through the block leaves one unassigned and no latch is inferred.
   always_comb begin
      cur_nib   = shadow.data[3:0];
      cur_blank = shadow.blank[0];
      cur_blink = shadow.blink[0];
      cur_dp    = shadow.dp[0];
      cur_lz    = lz_dark[0];
      an_next   = '1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (digit_idx == IW'(k)) begin
            cur_nib    = shadow.data[4*k +: 4];
            cur_blank  = shadow.blank[k];
            cur_blink  = shadow.blink[k];
            cur_dp     = shadow.dp[k];
            cur_lz     = lz_dark[k];
            an_next[k] = 1'b0;
         end
      end
      hard_dark = cur_blank || (cur_blink && !blink_on);
   end

   // Registered pin outputs: one clock behind the digit index, and
   // frame_start lines up with the first cycle digit 0 is driven.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an          <= '1;
         seg         <= SEG_DARK;
         dp          <= 1'b1;
         frame_start <= 1'b0;
         boundary_d  <= 1'b0;
      end else begin
         boundary_d  <= boundary;
         frame_start <= boundary_d;
         an          <= an_next;
         seg         <= (hard_dark || cur_lz) ? SEG_DARK : decode(cur_nib);
         dp          <= hard_dark ? 1'b1 : ~cur_dp;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (8 digits, 4 clocks per slot,
// 2 frames per blink half-period). Frame images are hand-written constants.

module tb_seg7_scan_driver;

   localparam int ND = 8;
   localparam int RD = 4;
   localparam int BF = 2;

   localparam logic [55:0] ALL_BLANK = {8{7'h7F}};

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [31:0]   display_data;
   logic          load;
   logic [ND-1:0] blank_mask;
   logic [ND-1:0] blink_mask;
   logic [ND-1:0] dp_mask;
   logic [ND-1:0] an;
   logic [6:0]    seg;
   logic          dp;
   logic          frame_start;

   int checks = 0;
   int errors = 0;

   seg7_scan_driver #(
      .NUM_DIGITS  (ND),
      .REFRESH_DIV (RD),
      .BLINK_FRAMES(BF)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .display_data(display_data),
      .load        (load),
      .blank_mask  (blank_mask),
      .blink_mask  (blink_mask),
      .dp_mask     (dp_mask),
      .an          (an),
      .seg         (seg),
      .dp          (dp),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [7:0]  blank;
      logic [7:0]  dpm;
      int          load_cycle;
      logic [55:0] exp_seg;   // digit k at [7k +: 7]
      logic [7:0]  exp_dp;    // expected dp pin per digit
   } vec_t;

   vec_t vecs[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Sample frame cycles first..last; the caller is already at cycle 'first'.
   task automatic check_range(input int first, input int last, input logic [55:0] exp_seg,
                              input logic [7:0] exp_dp, input bit check_fs0, input string tag);
      logic [7:0] exp_an;
      logic [6:0] es;
      int         k;
      for (int c = first; c <= last; c++) begin
         if (c != first) @(negedge clk);
         k      = c / RD;
         exp_an = ~(8'h01 << k);
         es     = exp_seg[7*k +: 7];
         check($sformatf("%s c%0d an", tag, c), 32'(an), 32'(exp_an));
         check($sformatf("%s c%0d seg", tag, c), 32'(seg), 32'(es));
         check($sformatf("%s c%0d dp", tag, c), 32'(dp), 32'(exp_dp[k]));
         if (c == 0) begin
            if (check_fs0) check($sformatf("%s c0 frame_start", tag), 32'(frame_start), 32'd1);
         end else begin
            check($sformatf("%s c%0d frame_start", tag, c), 32'(frame_start), 32'd0);
         end
      end
   endtask

   // Advance to the next frame_start cycle, bounded.
   task automatic wait_fs(input int exp_delay, input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_start && n < 100);
      check({tag, " frame_start seen"}, 32'(frame_start), 32'd1);
      if (exp_delay > 0) check({tag, " frame_start delay"}, 32'(n), 32'(exp_delay));
   endtask

   // Drive a one-cycle load from a negedge; returns one negedge later.
   task automatic pulse_load(input logic [31:0] data, input logic [7:0] blank,
                             input logic [7:0] blink, input logic [7:0] dpm);
      display_data = data;
      blank_mask   = blank;
      blink_mask   = blink;
      dp_mask      = dpm;
      load         = 1'b1;
      @(negedge clk);
      load         = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [55:0] cur_seg;
      logic [7:0]  cur_dp;
      logic [55:0] new_seg;
      logic [7:0]  new_dp;
      bit          on;

      display_data = '1;
      load         = 1'b0;
      blank_mask   = '0;
      blink_mask   = '0;
      dp_mask      = '0;

      vecs[0] = '{data: 32'hFFFFFF00, blank: 8'h00, dpm: 8'h00, load_cycle: 10,
                  exp_seg: {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40},
                  exp_dp: 8'hFF};
      vecs[1] = '{data: 32'h01234567, blank: 8'h00, dpm: 8'hA5, load_cycle: 3,
                  exp_seg: {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78},
                  exp_dp: 8'h5A};
      vecs[2] = '{data: 32'h89ABCDEF, blank: 8'h30, dpm: 8'hFF, load_cycle: 20,
                  exp_seg: {7'h00, 7'h10, 7'h7F, 7'h7F, 7'h46, 7'h21, 7'h06, 7'h7F},
                  exp_dp: 8'h30};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      vecs[3] = '{data: 32'hFF000705, blank: 8'h00, dpm: 8'h08, load_cycle: 28,
                  exp_seg: {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78, 7'h40, 7'h12},
                  exp_dp: 8'hF7};
`else
      vecs[3] = '{data: 32'hFF000705, blank: 8'h00, dpm: 8'h08, load_cycle: 28,
                  exp_seg: {7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40, 7'h78, 7'h40, 7'h12},
                  exp_dp: 8'hF7};
`endif

      // Reset values, held across a clock edge
      #2 reset = 1'b1;
      @(negedge clk);
      check("reset an", 32'(an), 32'hFF);
      check("reset seg", 32'(seg), 32'h7F);
      check("reset dp", 32'(dp), 32'd1);
      check("reset frame_start", 32'(frame_start), 32'd0);
      @(negedge clk);
      check("reset held an", 32'(an), 32'hFF);
      reset = 1'b0;

      // Blank scan after reset, then a full frame with frame_start timing
      @(negedge clk);
      check_range(0, 31, ALL_BLANK, 8'hFF, 1'b0, "t1 f0");
      wait_fs(1, "t1");
      check_range(0, 31, ALL_BLANK, 8'hFF, 1'b1, "t1 f1");
      cur_seg = ALL_BLANK;
      cur_dp  = 8'hFF;

      // Table: mid-frame load, old image stays for the rest of that frame
      for (int i = 0; i < 4; i++) begin
         wait_fs(1, $sformatf("v%0d", i));
         check_range(0, vecs[i].load_cycle, cur_seg, cur_dp, 1'b1, $sformatf("v%0d old", i));
         pulse_load(vecs[i].data, vecs[i].blank, 8'h00, vecs[i].dpm);
         check_range(vecs[i].load_cycle + 1, 31, cur_seg, cur_dp, 1'b0, $sformatf("v%0d old", i));
         wait_fs(1, $sformatf("v%0d new", i));
         check_range(0, 31, vecs[i].exp_seg, vecs[i].exp_dp, 1'b1, $sformatf("v%0d new", i));
         cur_seg = vecs[i].exp_seg;
         cur_dp  = vecs[i].exp_dp;
      end

      // Two loads in one frame: only the second one appears
      wait_fs(1, "t3");
      check_range(0, 5, cur_seg, cur_dp, 1'b1, "t3 old");
      pulse_load(32'h12345678, 8'h00, 8'h00, 8'h00);
      check_range(6, 15, cur_seg, cur_dp, 1'b0, "t3 old");
      pulse_load(32'hCDFFFF05, 8'h00, 8'h00, 8'h00);
      check_range(16, 31, cur_seg, cur_dp, 1'b0, "t3 old");
      new_seg = {7'h46, 7'h21, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h12};
      new_dp  = 8'hFF;
      wait_fs(1, "t3 new");
      check_range(0, 31, new_seg, new_dp, 1'b1, "t3 new");
      cur_seg = new_seg;
      cur_dp  = new_dp;

      // Load sampled on the boundary edge goes straight to the next frame
      wait_fs(1, "t4");
      check_range(0, 30, cur_seg, cur_dp, 1'b1, "t4 old");
      pulse_load(32'hFFFFFF3C, 8'h00, 8'h00, 8'h00);
      check_range(31, 31, cur_seg, cur_dp, 1'b0, "t4 old");
      new_seg = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h30, 7'h46};
      wait_fs(1, "t4 new");
      check_range(0, 31, new_seg, 8'hFF, 1'b1, "t4 new");

      // Asynchronous reset mid-scan
      repeat (10) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("async reset an", 32'(an), 32'hFF);
      check("async reset seg", 32'(seg), 32'h7F);
      check("async reset dp", 32'(dp), 32'd1);
      check("async reset frame_start", 32'(frame_start), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Blink: first tick REFRESH_DIV cycles after release, then 2 on / 2 off
      @(negedge clk);
      check_range(0, 4, ALL_BLANK, 8'hFF, 1'b0, "t5 f0");
      pulse_load(32'h11111118, 8'h00, 8'h01, 8'h01);
      check_range(5, 31, ALL_BLANK, 8'hFF, 1'b0, "t5 f0");
      for (int f = 1; f <= 6; f++) begin
         on = ((f / 2) % 2) == 0;
         wait_fs(1, $sformatf("t5 f%0d", f));
         if (on)
            check_range(0, 31, {{7{7'h79}}, 7'h00}, 8'hFE, 1'b1, $sformatf("t5 f%0d on", f));
         else
            check_range(0, 31, {{7{7'h79}}, 7'h7F}, 8'hFF, 1'b1, $sformatf("t5 f%0d off", f));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
